// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with same-cycle writeback bypass, load-use stall and branch-flush squash.
// Latency: 1 cycle from ID inputs to ex_* outputs; stall is combinational in the same cycle.
// Backpressure: a load-use hazard raises stall (IF/ID holds) and injects one bubble; flush overrides stall.
module id_ex_stage #(
  parameter int DW   = 32,
  parameter int CW   = 16,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            id_uses_rt,
  input  logic [4:0]      id_rd,
  input  logic            id_regwr,
  input  logic            id_memrd,
  input  logic [DW-1:0]   id_busA,
  input  logic [DW-1:0]   id_busB,
  input  logic [DW-1:0]   id_imm,
  input  logic [CW-1:0]   id_ctrl,
  input  logic            wb_regwr,
  input  logic [4:0]      wb_rw,
  input  logic [DW-1:0]   wb_data,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic            ex_regwr,
  output logic            ex_memrd,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [DW-1:0]   ex_a,
  output logic [DW-1:0]   ex_b,
  output logic [DW-1:0]   ex_imm,
  output logic [CW-1:0]   ex_ctrl,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  logic            ex_valid_q, ex_valid_d;
  logic            ex_regwr_q, ex_regwr_d;
  logic            ex_memrd_q, ex_memrd_d;
  logic [4:0]      ex_rs_q, ex_rs_d;
  logic [4:0]      ex_rt_q, ex_rt_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic [DW-1:0]   ex_a_q, ex_a_d;
  logic [DW-1:0]   ex_b_q, ex_b_d;
  logic [DW-1:0]   ex_imm_q, ex_imm_d;
  logic [CW-1:0]   ex_ctrl_q, ex_ctrl_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

  logic            haz;
  logic [DW-1:0]   opa_byp;
  logic [DW-1:0]   opb_byp;

  // Load-use detection against the load sitting in EX, and WB bypass of the stale regfile read.
  // r0 is never a hazard source (ex_rd != 0) and never bypassed (wb_rw != 0).
  always_comb begin
    haz = ex_valid_q & ex_memrd_q & ex_regwr_q & (ex_rd_q != 5'd0) & id_valid &
          ((id_rs == ex_rd_q) | (id_uses_rt & (id_rt == ex_rd_q)));
    opa_byp = (wb_regwr && (wb_rw != 5'd0) && (wb_rw == id_rs)) ? wb_data : id_busA;
    opb_byp = (wb_regwr && (wb_rw != 5'd0) && (wb_rw == id_rt)) ? wb_data : id_busB;
  end

  assign stall = haz & ~flush;

  // Next state: flush beats hazard beats normal capture; bubbles only clear the qualifier bits.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_regwr_d  = ex_regwr_q;
    ex_memrd_d  = ex_memrd_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_rd_d     = ex_rd_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_imm_d    = ex_imm_q;
    ex_ctrl_d   = ex_ctrl_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_regwr_d = 1'b0;
      ex_memrd_d = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNTW'(1);
    end else if (haz) begin
      ex_valid_d = 1'b0;
      ex_regwr_d = 1'b0;
      ex_memrd_d = 1'b0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNTW'(1);
    end else begin
      ex_valid_d = id_valid;
      ex_regwr_d = id_regwr & id_valid;
      ex_memrd_d = id_memrd & id_valid;
      ex_rs_d    = id_rs;
      ex_rt_d    = id_rt;
      ex_rd_d    = id_rd;
      ex_a_d     = opa_byp;
      ex_b_d     = opb_byp;
      ex_imm_d   = id_imm;
      ex_ctrl_d  = id_ctrl;
    end
  end

  // Pipeline register and counters; async reset clears everything including in-flight bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_regwr_q  <= 1'b0;
      ex_memrd_q  <= 1'b0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_imm_q    <= '0;
      ex_ctrl_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_regwr_q  <= ex_regwr_d;
      ex_memrd_q  <= ex_memrd_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_imm_q    <= ex_imm_d;
      ex_ctrl_q   <= ex_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_regwr  = ex_regwr_q;
  assign ex_memrd  = ex_memrd_q;
  assign ex_rs     = ex_rs_q;
  assign ex_rt     = ex_rt_q;
  assign ex_rd     = ex_rd_q;
  assign ex_a      = ex_a_q;
  assign ex_b      = ex_b_q;
  assign ex_imm    = ex_imm_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model pushes expected EX state per cycle, popped after the edge.
// Latency: expectations are compared 1 ns after each rising edge; stall is checked before the edge.
// Backpressure: hazard cycles are modelled explicitly; counters use a narrow width to reach saturation.
module tb_id_ex_stage;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_uses_rt, id_regwr, id_memrd;
  logic [4:0]      id_rs, id_rt, id_rd;
  logic [DW-1:0]   id_busA, id_busB, id_imm;
  logic [CW-1:0]   id_ctrl;
  logic            wb_regwr;
  logic [4:0]      wb_rw;
  logic [DW-1:0]   wb_data;
  logic            flush;
  logic            stall, ex_valid, ex_regwr, ex_memrd;
  logic [4:0]      ex_rs, ex_rt, ex_rd;
  logic [DW-1:0]   ex_a, ex_b, ex_imm;
  logic [CW-1:0]   ex_ctrl;
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic            v, rw, mr;
    logic [4:0]      rs, rt, rd;
    logic [DW-1:0]   a, b, imm;
    logic [CW-1:0]   ctrl;
    logic [CNTW-1:0] sc, fc;
  } exp_t;

  exp_t m;
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  id_ex_stage #(.DW(DW), .CW(CW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwr(id_regwr), .id_memrd(id_memrd),
    .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_regwr(wb_regwr), .wb_rw(wb_rw), .wb_data(wb_data), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ex_valid"}, ex_valid, 0);
    chk({tag, " ex_regwr"}, ex_regwr, 0);
    chk({tag, " ex_memrd"}, ex_memrd, 0);
    chk({tag, " ex_regs"}, {ex_rs, ex_rt, ex_rd}, 0);
    chk({tag, " ex_a"}, ex_a, 0);
    chk({tag, " ex_b"}, ex_b, 0);
    chk({tag, " ex_imm"}, ex_imm, 0);
    chk({tag, " ex_ctrl"}, ex_ctrl, 0);
    chk({tag, " cnts"}, {stall_cnt, flush_cnt}, 0);
    chk({tag, " stall"}, stall, 0);
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rt = 0; id_regwr = 0; id_memrd = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_busA = 0; id_busB = 0; id_imm = 0; id_ctrl = 0;
    wb_regwr = 0; wb_rw = 0; wb_data = 0; flush = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic rw, input logic mr);
    idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_rd = rd;
    id_regwr = rw; id_memrd = mr;
    id_busA = 32'h1000_0000 | 32'(rs); id_busB = 32'h2000_0000 | 32'(rt);
    id_imm = 32'h0000_0040; id_ctrl = 16'hC0DE;
  endtask

  // One clock: check stall from the model, predict next EX state, push, clock, pop and compare.
  task automatic cyc();
    exp_t e;
    logic hz;
    #1;
    hz = m.v & m.mr & m.rw & (m.rd != 5'd0) & id_valid &
         ((id_rs == m.rd) | (id_uses_rt & (id_rt == m.rd)));
    chk("stall", stall, hz & ~flush);
    e = m;
    if (flush || hz) begin
      e.v = 0; e.rw = 0; e.mr = 0;
      if (flush) begin
        if (e.fc != '1) e.fc = e.fc + 1'b1;
      end else if (e.sc != '1) e.sc = e.sc + 1'b1;
    end else begin
      e.v = id_valid; e.rw = id_regwr & id_valid; e.mr = id_memrd & id_valid;
      e.rs = id_rs; e.rt = id_rt; e.rd = id_rd; e.imm = id_imm; e.ctrl = id_ctrl;
      e.a = (wb_regwr && wb_rw != 0 && wb_rw == id_rs) ? wb_data : id_busA;
      e.b = (wb_regwr && wb_rw != 0 && wb_rw == id_rt) ? wb_data : id_busB;
    end
    m = e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("scoreboard empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("ex_valid", ex_valid, e.v);
      chk("ex_regwr", ex_regwr, e.rw);
      chk("ex_memrd", ex_memrd, e.mr);
      if (e.v) begin
        chk("ex_rs_rt_rd", {ex_rs, ex_rt, ex_rd}, {e.rs, e.rt, e.rd});
        chk("ex_a", ex_a, e.a);
        chk("ex_b", ex_b, e.b);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_ctrl", ex_ctrl, e.ctrl);
      end
      chk("stall_cnt", stall_cnt, e.sc);
      chk("flush_cnt", flush_cnt, e.fc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    // Reset held with random inputs
    rst = 0;
    idle();
    for (int i = 0; i < 3; i++) begin
      id_valid = 1; id_regwr = 1; id_memrd = 1; flush = 1'($urandom);
      id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
      id_busA = $urandom; id_busB = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
      @(posedge clk); #1;
      chk_all_zero("reset");
    end
    rst = 1;
    idle();

    // Pass-through
    instr(5'd3, 5'd4, 1, 5'd9, 1, 0);
    id_busA = 32'h11; id_busB = 32'h22; id_imm = 32'hFFFF_FFF0;
    cyc();
    chk("pass ex_a", ex_a, 32'h11);
    chk("pass ex_b", ex_b, 32'h22);
    chk("pass ex_imm", ex_imm, 32'hFFFF_FFF0);
    chk("pass ex_valid", ex_valid, 1);

    // WB bypass on A, then r0 never bypassed
    instr(5'd5, 5'd6, 1, 5'd2, 1, 0);
    id_busA = 32'hAAAA; wb_regwr = 1; wb_rw = 5'd5; wb_data = 32'h1234;
    cyc();
    chk("byp ex_a", ex_a, 32'h1234);
    instr(5'd0, 5'd6, 1, 5'd2, 1, 0);
    id_busA = 32'h5555; wb_regwr = 1; wb_rw = 5'd0; wb_data = 32'h1234;
    cyc();
    chk("r0 ex_a", ex_a, 32'h5555);
    instr(5'd1, 5'd6, 1, 5'd2, 1, 0);
    wb_regwr = 1; wb_rw = 5'd6; wb_data = 32'hBEEF;
    cyc();
    chk("byp ex_b", ex_b, 32'hBEEF);

    // Load-use on rs: one stall, bubble, then capture
    instr(5'd1, 5'd2, 0, 5'd7, 1, 1);
    cyc();
    instr(5'd7, 5'd8, 1, 5'd10, 1, 0);
    #1; chk("lu stall", stall, 1);
    cyc();
    chk("lu bubble", ex_valid, 0);
    chk("lu stall_cnt", stall_cnt, 1);
    cyc();
    chk("lu captured", {ex_valid, ex_rs}, {1'b1, 5'd7});
    // rt matches but not used as operand: no stall
    instr(5'd1, 5'd2, 0, 5'd7, 1, 1);
    cyc();
    instr(5'd1, 5'd7, 0, 5'd10, 1, 0);
    #1; chk("lu no-rt stall", stall, 0);
    cyc();
    // rt used: stall
    instr(5'd1, 5'd2, 0, 5'd7, 1, 1);
    cyc();
    instr(5'd1, 5'd7, 1, 5'd10, 1, 0);
    cyc();
    cyc();

    // Flush with hazard in the same cycle
    instr(5'd1, 5'd2, 0, 5'd7, 1, 1);
    cyc();
    instr(5'd7, 5'd8, 1, 5'd10, 1, 0);
    flush = 1;
    cyc();
    chk("fl bubble", ex_valid, 0);
    chk("fl flush_cnt", flush_cnt, 1);
    chk("fl stall_cnt", stall_cnt, 2);

    // Saturation: 2^CNTW+3 stall events
    for (int i = 0; i < (1 << CNTW) + 3; i++) begin
      instr(5'd1, 5'd2, 0, 5'd7, 1, 1);
      cyc();
      instr(5'd7, 5'd8, 1, 5'd10, 1, 0);
      cyc();
    end
    chk("sat stall_cnt", stall_cnt, {CNTW{1'b1}});
    // Load to r0 never stalls
    instr(5'd1, 5'd2, 0, 5'd0, 1, 1);
    cyc();
    instr(5'd0, 5'd0, 1, 5'd10, 1, 0);
    #1; chk("r0 load stall", stall, 0);
    cyc();

    // Mid-operation reset with a load pending in EX
    instr(5'd1, 5'd2, 0, 5'd7, 1, 1);
    cyc();
    instr(5'd7, 5'd8, 1, 5'd10, 1, 0);
    #3; rst = 0; #1;
    chk_all_zero("midrst");
    m = '0;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1;
    cyc();
    chk("post-rst captured", ex_valid, 1);

    // Random traffic over a small register range
    for (int i = 0; i < 300; i++) begin
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_uses_rt = 1'($urandom);
      id_regwr = 1'($urandom); id_memrd = 1'($urandom);
      id_busA = $urandom; id_busB = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
      wb_regwr = 1'($urandom); wb_rw = 5'($urandom_range(0, 3)); wb_data = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
